pwm_capture: RTL and testbench

- Measures an external PWM waveform. It is the receive-side counterpart of the PWM generator.
- Synchronises the pin, detects edges, and counts `clk` cycles to report period and high time for each complete cycle.
- Sits beside the counter/regs peripheral. Results are read back through the register block.

---
 rtl/pwm_capture.sv | 187 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture with pin synchroniser and edge-driven measurement FSM
// Optional glitch filter on the synchronised level when PWM_CAPTURE_GLITCH_FILTER_EN is defined.
`timescale 1ns/1ps
module pwm_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  ,
  parameter int FILTER_LEN  = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  output logic             timeout,
  output logic             level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   level_d;
  logic                   cap_en_d;
  logic                   rise;
  logic                   fall;
  logic                   cap_rise;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]       high_lat_q, high_lat_d;
  logic [CNT_W-1:0]       period_d, high_d;
  logic                   valid_d;
  logic                   timeout_d;
  logic                   sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  // Level flips only after FILTER_LEN consecutive samples disagree with it,
  // so both edges see the same extra FILTER_LEN-cycle delay.
  localparam int RUN_W = $clog2(FILTER_LEN + 1);

  logic [RUN_W-1:0] run_q;
  logic             filt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_out == filt_q) begin
      run_q  <= '0;
    end else if (run_q == RUN_W'(FILTER_LEN - 1)) begin
      run_q  <= '0;
      filt_q <= sync_out;
    end else begin
      run_q  <= run_q + RUN_W'(1);
    end
  end

  assign level = filt_q;
`else
  assign level = sync_out;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d  <= 1'b0;
      cap_en_d <= 1'b0;
    end else begin
      level_d  <= level;
      cap_en_d <= cap_en;
    end
  end

  assign rise     = level & ~level_d;
  assign fall     = ~level & level_d;
  assign cap_rise = cap_en & ~cap_en_d;
  assign sat      = (cnt_q == CNT_MAX);
  assign cnt_inc  = sat ? CNT_MAX : cnt_q + CNT_ONE;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_lat_d = high_lat_q;
    period_d   = meas_period;
    high_d     = meas_high;
    valid_d    = 1'b0;
    timeout_d  = timeout;

    if (!cap_en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      if (cap_rise) begin
        timeout_d = 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
          cnt_d   = '0;
        end
        // First rise after arming only starts the count; the partial cycle before it is dropped.
        S_ARM: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = S_HIGH;
          end
        end
        S_HIGH: begin
          if (fall) begin
            high_lat_d = cnt_q;
            cnt_d      = cnt_inc;
            state_d    = S_LOW;
          end else if (sat) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_ARM;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_LOW: begin
          if (rise) begin
            period_d  = cnt_q;
            high_d    = high_lat_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
            state_d   = S_HIGH;
          end else if (sat) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_ARM;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      high_lat_q  <= '0;
      meas_period <= '0;
      meas_high   <= '0;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      high_lat_q  <= high_lat_d;
      meas_period <= period_d;
      meas_high   <= high_d;
      meas_valid  <= valid_d;
      timeout     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture driven by randomized PWM waveforms
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 16;
  localparam int MAXC        = (1 << CNT_W) - 1;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FILTER_LEN  = 4;
  localparam int LAT         = SYNC_STAGES + FILTER_LEN + 1;
  localparam int MINW        = FILTER_LEN;
`else
  localparam int LAT         = SYNC_STAGES + 1;
  localparam int MINW        = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cap_en;
  logic             pwm_in;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             meas_valid;
  logic             timeout;
  logic             level;

  pwm_capture dut (
    .clk         (clk),
    .rst         (rst),
    .cap_en      (cap_en),
    .pwm_in      (pwm_in),
    .meas_period (meas_period),
    .meas_high   (meas_high),
    .meas_valid  (meas_valid),
    .timeout     (timeout),
    .level       (level)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     period;
    int     high;
    longint when;
  } exp_t;

  exp_t   q[$];
  exp_t   got;
  int     errors = 0;
  int     checks = 0;
  bit     have_prev;
  longint last_rise;
  longint last_fall;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a measurement is the pair of edges (rise..fall..rise) as driven on the pin;
  // the result appears a fixed pipeline latency after the closing rise is driven.
  task automatic set_pin(input bit v);
    exp_t e;
    if (v && !pwm_in) begin
      if (have_prev) begin
        e.period = int'(cyc - last_rise);
        e.high   = int'(last_fall - last_rise);
        e.when   = cyc + LAT;
        q.push_back(e);
      end
      have_prev = 1'b1;
      last_rise = cyc;
    end else if (!v && pwm_in) begin
      last_fall = cyc;
    end
    pwm_in = v;
  endtask

  task automatic pwm_cycle(input int h, input int l);
    set_pin(1'b1);
    repeat (h) tick();
    set_pin(1'b0);
    repeat (l) tick();
  endtask

  // 30-cycle high with a 2-cycle low glitch at offset 10, period 100.
  task automatic glitch_cycle();
    set_pin(1'b1);
    repeat (10) tick();
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    pwm_in = 1'b0;
    repeat (2) tick();
    pwm_in = 1'b1;
`else
    set_pin(1'b0);
    repeat (2) tick();
    set_pin(1'b1);
`endif
    repeat (18) tick();
    set_pin(1'b0);
    repeat (70) tick();
  endtask

  always @(negedge clk) begin
    if (!rst && meas_valid) begin
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_strobe: period %0d high %0d at cycle %0d, expected no strobe",
                 meas_period, meas_high, cyc);
      end else begin
        got = q.pop_front();
        check("meas_period", longint'(meas_period), longint'(got.period));
        check("meas_high", longint'(meas_high), longint'(got.high));
        check("strobe_cycle", cyc, got.when);
        check("timeout_at_strobe", longint'(timeout), 0);
      end
    end
  end

  initial begin
    int h;
    int l;
    rst       = 1'b1;
    cap_en    = 1'b0;
    pwm_in    = 1'b0;
    have_prev = 1'b0;
    last_rise = 0;
    last_fall = 0;

    repeat (3) tick();
    check("rst_period", longint'(meas_period), 0);
    check("rst_high", longint'(meas_high), 0);
    check("rst_valid", longint'(meas_valid), 0);
    check("rst_timeout", longint'(timeout), 0);
    check("rst_level", longint'(level), 0);
    rst = 1'b0;
    repeat (2) tick();
    cap_en = 1'b1;
    repeat (3) tick();

    repeat (6) pwm_cycle(30, 70);

    repeat (4) pwm_cycle(10, 40);
    repeat (4) pwm_cycle(40, 10);

    repeat (40) begin
      h = int'($urandom_range(MINW, 40));
      l = int'($urandom_range(MINW, 40));
      pwm_cycle(h, l);
    end
    repeat (3) pwm_cycle(MINW, MINW);

    glitch_cycle();
    pwm_cycle(30, 70);

    // Drop enable 20 cycles into a high phase; the aborted cycle must not report.
    set_pin(1'b1);
    repeat (20) tick();
    cap_en    = 1'b0;
    have_prev = 1'b0;
    repeat (5) tick();
    cap_en = 1'b1;
    repeat (15) tick();
    set_pin(1'b0);
    repeat (60) tick();
    repeat (3) pwm_cycle(25, 45);

    // Asynchronous reset in the middle of a low phase.
    set_pin(1'b1);
    repeat (20) tick();
    set_pin(1'b0);
    repeat (30) tick();
    #3 rst = 1'b1;
    #1;
    check("async_rst_period", longint'(meas_period), 0);
    check("async_rst_high", longint'(meas_high), 0);
    check("async_rst_valid", longint'(meas_valid), 0);
    check("async_rst_timeout", longint'(timeout), 0);
    check("async_rst_level", longint'(level), 0);
    have_prev = 1'b0;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    repeat (3) pwm_cycle(15, 35);

    // Constant high after a rise: timeout exactly when the counter saturates.
    set_pin(1'b1);
    repeat (LAT - 1 + MAXC) tick();
    check("timeout_before_sat", longint'(timeout), 0);
    check("level_high", longint'(level), 1);
    tick();
    check("timeout_at_sat", longint'(timeout), 1);
    repeat (70000 - LAT - MAXC) tick();
    have_prev = 1'b0;
    set_pin(1'b0);
    repeat (30) tick();
    pwm_cycle(25, 25);
    check("timeout_sticky", longint'(timeout), 1);
    repeat (2) pwm_cycle(25, 25);
    check("timeout_cleared", longint'(timeout), 0);

    repeat (20) tick();
    check("queue_drained", longint'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
